// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two-requester round-robin front end for a single shared FPU.
// Only one operation is in flight at a time. The op fields are latched at grant,
// held toward the FPU, and the result (or a timeout error) is presented with the
// requester id and tag until the consumer takes it.
module fpu_arbiter #(
    parameter int LEN_WORD  = 32,
    parameter int LEN_FUNC3 = 3,
    parameter int LEN_FUNC7 = 7,
    parameter int LEN_TAG   = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req0_valid,
    input  logic [LEN_FUNC3-1:0] req0_func3,
    input  logic [LEN_FUNC7-1:0] req0_func7,
    input  logic [LEN_WORD-1:0]  req0_rs1,
    input  logic [LEN_WORD-1:0]  req0_rs2,
    input  logic [LEN_TAG-1:0]   req0_tag,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [LEN_FUNC3-1:0] req1_func3,
    input  logic [LEN_FUNC7-1:0] req1_func7,
    input  logic [LEN_WORD-1:0]  req1_rs1,
    input  logic [LEN_WORD-1:0]  req1_rs2,
    input  logic [LEN_TAG-1:0]   req1_tag,
    output logic                 req1_ready,
    output logic                 fpu_order,
    output logic [LEN_FUNC3-1:0] fpu_func3,
    output logic [LEN_FUNC7-1:0] fpu_func7,
    output logic [LEN_WORD-1:0]  fpu_rs1,
    output logic [LEN_WORD-1:0]  fpu_rs2,
    input  logic                 fpu_accepted,
    input  logic                 fpu_calculated,
    input  logic [LEN_WORD-1:0]  fpu_rd,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [LEN_TAG-1:0]   resp_tag,
    output logic [LEN_WORD-1:0]  resp_data,
    output logic                 resp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [LEN_FUNC3-1:0] func3;
        logic [LEN_FUNC7-1:0] func7;
        logic [LEN_WORD-1:0]  rs1;
        logic [LEN_WORD-1:0]  rs2;
        logic [LEN_TAG-1:0]   tag;
    } req_t;

    // Last WAIT count value before giving up; the counter starts at 0 on entry,
    // so this yields exactly TIMEOUT WAIT cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t         state, state_nxt;
    logic [15:0]    cnt;
    logic           last_grant;
    logic           gnt0, gnt1, take;
    req_t           req0_s, req1_s, req_sel, op_q;
    logic           id_q, err_q;
    logic [LEN_WORD-1:0] data_q;

    assign req0_s  = '{func3: req0_func3, func7: req0_func7, rs1: req0_rs1, rs2: req0_rs2, tag: req0_tag};
    assign req1_s  = '{func3: req1_func3, func7: req1_func7, rs1: req1_rs1, rs2: req1_rs2, tag: req1_tag};
    assign req_sel = gnt1 ? req1_s : req0_s;
    assign take    = gnt0 | gnt1;

    // Grant in IDLE only; on contention the requester that did not win last time wins.
    // Gated with rstn so ready stays low while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && rstn) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; FPU handshake inputs only matter in ISSUE and WAIT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (take) state_nxt = ISSUE;
            ISSUE: if (fpu_accepted) state_nxt = fpu_calculated ? RESP : WAIT;
            WAIT:  if (fpu_calculated || cnt == TO_LAST) state_nxt = RESP;
            RESP:  if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operation latch, round-robin history, WAIT counter and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q       <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            data_q     <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: if (take) begin
                    op_q       <= req_sel;
                    id_q       <= gnt1;
                    last_grant <= gnt1;
                    data_q     <= '0;
                    err_q      <= 1'b0;
                end
                ISSUE: if (fpu_accepted) begin
                    if (fpu_calculated) begin
                        data_q <= fpu_rd;
                        err_q  <= 1'b0;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still wins over timeout.
                    if (fpu_calculated) begin
                        data_q <= fpu_rd;
                        err_q  <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign fpu_order  = (state == ISSUE);
    assign fpu_func3  = op_q.func3;
    assign fpu_func7  = op_q.func7;
    assign fpu_rs1    = op_q.rs1;
    assign fpu_rs2    = op_q.rs2;
    assign resp_valid = (state == RESP);
    assign resp_id    = id_q;
    assign resp_tag   = op_q.tag;
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: table-driven grant/round-robin/datapath vectors plus directed
// sequences for multicycle, timeout, backpressure and mid-operation reset.
// Instance m uses the default TIMEOUT, instance t uses TIMEOUT=4; both share inputs.
module tb_fpu_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_func3, req1_func3;
    logic [6:0]  req0_func7, req1_func7;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [4:0]  req0_tag, req1_tag;
    logic        fpu_accepted, fpu_calculated, resp_ready;
    logic [31:0] fpu_rd;

    logic        m_r0rdy, m_r1rdy, m_order, m_rvalid, m_rid, m_rerr, m_busy;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_rs1, m_rs2, m_rdata;
    logic [4:0]  m_rtag;
    logic        t_r0rdy, t_r1rdy, t_order, t_rvalid, t_rid, t_rerr, t_busy;
    logic [2:0]  t_f3;
    logic [6:0]  t_f7;
    logic [31:0] t_rs1, t_rs2, t_rdata;
    logic [4:0]  t_rtag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_arbiter m_dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_func3(req0_func3), .req0_func7(req0_func7),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_tag(req0_tag), .req0_ready(m_r0rdy),
        .req1_valid(req1_valid), .req1_func3(req1_func3), .req1_func7(req1_func7),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_tag(req1_tag), .req1_ready(m_r1rdy),
        .fpu_order(m_order), .fpu_func3(m_f3), .fpu_func7(m_f7), .fpu_rs1(m_rs1), .fpu_rs2(m_rs2),
        .fpu_accepted(fpu_accepted), .fpu_calculated(fpu_calculated), .fpu_rd(fpu_rd),
        .resp_valid(m_rvalid), .resp_ready(resp_ready), .resp_id(m_rid), .resp_tag(m_rtag),
        .resp_data(m_rdata), .resp_err(m_rerr), .busy(m_busy)
    );

    fpu_arbiter #(.TIMEOUT(4)) t_dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_func3(req0_func3), .req0_func7(req0_func7),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_tag(req0_tag), .req0_ready(t_r0rdy),
        .req1_valid(req1_valid), .req1_func3(req1_func3), .req1_func7(req1_func7),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_tag(req1_tag), .req1_ready(t_r1rdy),
        .fpu_order(t_order), .fpu_func3(t_f3), .fpu_func7(t_f7), .fpu_rs1(t_rs1), .fpu_rs2(t_rs2),
        .fpu_accepted(fpu_accepted), .fpu_calculated(fpu_calculated), .fpu_rd(fpu_rd),
        .resp_valid(t_rvalid), .resp_ready(resp_ready), .resp_id(t_rid), .resp_tag(t_rtag),
        .resp_data(t_rdata), .resp_err(t_rerr), .busy(t_busy)
    );

    typedef struct {
        logic        rst;
        logic        v0, v1;
        logic [31:0] rs1_0, rs1_1;
        logic [4:0]  tag0, tag1;
        logic [2:0]  f3_0, f3_1;
        logic [31:0] rd;
        logic        exp_id;
        logic [31:0] exp_rs1, exp_rs2;
        logic [4:0]  exp_tag;
        logic [2:0]  exp_f3;
        logic [6:0]  exp_f7;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next cycle, just after the active edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_func3 = 0; req1_func3 = 0;
        req0_func7 = 7'h00; req1_func7 = 7'h10;
        req0_rs1 = 0; req1_rs1 = 0;
        req0_rs2 = 32'h4000_0000; req1_rs2 = 32'h1111_1111;
        req0_tag = 0; req1_tag = 0;
        fpu_accepted = 0; fpu_calculated = 0; fpu_rd = 0;
        resp_ready = 1;
        nxt();
        nxt();
        rstn = 1'b1;
    endtask

    initial begin
        //      rst v0 v1 rs1_0          rs1_1          t0 t1  f30 f31 rd             id rs1            rs2            tag f3 f7
        vt[0] = '{1, 1, 0, 32'h3F80_0000, 32'h0,         3, 9,  0, 1, 32'h4040_0000, 0, 32'h3F80_0000, 32'h4000_0000, 3,  0, 7'h00};
        vt[1] = '{1, 1, 1, 32'hA000_0001, 32'hB000_0001, 1, 17, 0, 1, 32'hC000_0001, 0, 32'hA000_0001, 32'h4000_0000, 1,  0, 7'h00};
        vt[2] = '{0, 1, 1, 32'hA000_0002, 32'hB000_0002, 2, 18, 2, 3, 32'hC000_0002, 1, 32'hB000_0002, 32'h1111_1111, 18, 3, 7'h10};
        vt[3] = '{0, 1, 1, 32'hA000_0003, 32'hB000_0003, 4, 20, 4, 5, 32'hC000_0003, 0, 32'hA000_0003, 32'h4000_0000, 4,  4, 7'h00};
        vt[4] = '{0, 1, 1, 32'hA000_0004, 32'hB000_0004, 5, 21, 6, 7, 32'hC000_0004, 1, 32'hB000_0004, 32'h1111_1111, 21, 7, 7'h10};
        vt[5] = '{0, 0, 1, 32'hA000_0005, 32'hB000_0005, 6, 22, 0, 1, 32'hC000_0005, 1, 32'hB000_0005, 32'h1111_1111, 22, 1, 7'h10};
        vt[6] = '{0, 1, 1, 32'hA000_0006, 32'hB000_0006, 7, 23, 2, 3, 32'hC000_0006, 0, 32'hA000_0006, 32'h4000_0000, 7,  2, 7'h00};
        vt[7] = '{0, 1, 0, 32'hA000_0007, 32'hB000_0007, 8, 24, 4, 5, 32'hC000_0007, 0, 32'hA000_0007, 32'h4000_0000, 8,  4, 7'h00};
        vt[8] = '{0, 1, 1, 32'hA000_0008, 32'hB000_0008, 9, 25, 6, 7, 32'hC000_0008, 1, 32'hB000_0008, 32'h1111_1111, 25, 7, 7'h10};

        // Reset state: outputs low even with both requests asserted.
        do_reset();
        rstn = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #3;
        chk("rst_r0rdy", m_r0rdy, 0);
        chk("rst_r1rdy", m_r1rdy, 0);
        chk("rst_order", m_order, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_rs1", m_rs1, 0);
        chk("rst_rdata", m_rdata, 0);

        // Table: grant, ISSUE, immediate completion, RESP.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].rst) do_reset();
            req0_valid = vt[i].v0; req1_valid = vt[i].v1;
            req0_rs1 = vt[i].rs1_0; req1_rs1 = vt[i].rs1_1;
            req0_tag = vt[i].tag0;  req1_tag = vt[i].tag1;
            req0_func3 = vt[i].f3_0; req1_func3 = vt[i].f3_1;
            #2;
            chk($sformatf("v%0d_r0rdy", i), m_r0rdy, vt[i].exp_id == 1'b0);
            chk($sformatf("v%0d_r1rdy", i), m_r1rdy, vt[i].exp_id == 1'b1);
            chk($sformatf("v%0d_idle_busy", i), m_busy, 0);
            nxt();
            fpu_accepted = 1; fpu_calculated = 1; fpu_rd = vt[i].rd;
            #2;
            chk($sformatf("v%0d_order", i), m_order, 1);
            chk($sformatf("v%0d_iss_rdy", i), {m_r0rdy, m_r1rdy}, 0);
            chk($sformatf("v%0d_rs1", i), m_rs1, vt[i].exp_rs1);
            chk($sformatf("v%0d_rs2", i), m_rs2, vt[i].exp_rs2);
            chk($sformatf("v%0d_f3", i), m_f3, vt[i].exp_f3);
            chk($sformatf("v%0d_f7", i), m_f7, vt[i].exp_f7);
            chk($sformatf("v%0d_iss_rvalid", i), m_rvalid, 0);
            nxt();
            fpu_accepted = 0; fpu_calculated = 0;
            #2;
            chk($sformatf("v%0d_rvalid", i), m_rvalid, 1);
            chk($sformatf("v%0d_rid", i), m_rid, vt[i].exp_id);
            chk($sformatf("v%0d_rtag", i), m_rtag, vt[i].exp_tag);
            chk($sformatf("v%0d_rdata", i), m_rdata, vt[i].rd);
            chk($sformatf("v%0d_rerr", i), m_rerr, 0);
            chk($sformatf("v%0d_resp_order", i), m_order, 0);
            chk($sformatf("v%0d_resp_rdy", i), {m_r0rdy, m_r1rdy}, 0);
            nxt();
        end

        // Multicycle: accepted at T+1, calculated at T+9, response at T+10.
        do_reset();
        req0_valid = 1; req0_rs1 = 32'h1234_5678; req0_rs2 = 32'h9ABC_DEF0; req0_tag = 11;
        #2 chk("mc_r0rdy", m_r0rdy, 1);
        nxt();
        req0_valid = 0; req0_rs1 = 32'hFFFF_FFFF; req0_rs2 = 32'hEEEE_EEEE;
        fpu_accepted = 1;
        #2 chk("mc_order_t1", m_order, 1);
        for (int c = 2; c <= 9; c++) begin
            nxt();
            fpu_accepted = 0;
            fpu_calculated = (c == 9);
            fpu_rd = 32'h4120_0000;
            #2;
            chk($sformatf("mc_order_t%0d", c), m_order, 0);
            chk($sformatf("mc_rs1_t%0d", c), m_rs1, 32'h1234_5678);
            chk($sformatf("mc_rs2_t%0d", c), m_rs2, 32'h9ABC_DEF0);
            chk($sformatf("mc_rvalid_t%0d", c), m_rvalid, 0);
            chk($sformatf("mc_busy_t%0d", c), m_busy, 1);
        end
        nxt();
        fpu_calculated = 0;
        #2;
        chk("mc_rvalid_t10", m_rvalid, 1);
        chk("mc_rdata", m_rdata, 32'h4120_0000);
        chk("mc_rtag", m_rtag, 11);
        chk("mc_rerr", m_rerr, 0);
        nxt();

        // Timeout on the TIMEOUT=4 instance, then a late calculated pulse in IDLE.
        do_reset();
        req0_valid = 1; req0_rs1 = 32'h0000_0042; req0_tag = 5;
        #2 chk("to_r0rdy", t_r0rdy, 1);
        nxt();
        req0_valid = 0; fpu_accepted = 1; fpu_rd = 32'hDEAD_BEEF;
        #2 chk("to_order", t_order, 1);
        for (int c = 0; c < 4; c++) begin
            nxt();
            fpu_accepted = 0;
            #2;
            chk($sformatf("to_wait%0d_rvalid", c), t_rvalid, 0);
            chk($sformatf("to_wait%0d_busy", c), t_busy, 1);
        end
        nxt();
        #2;
        chk("to_rvalid", t_rvalid, 1);
        chk("to_rerr", t_rerr, 1);
        chk("to_rdata", t_rdata, 0);
        chk("to_rtag", t_rtag, 5);
        nxt();
        fpu_calculated = 1;
        #2;
        chk("to_late_busy", t_busy, 0);
        nxt();
        fpu_calculated = 0;
        #2;
        chk("to_late_rvalid", t_rvalid, 0);
        chk("to_late_busy2", t_busy, 0);

        // Calculated on the final WAIT cycle beats the timeout.
        do_reset();
        req0_valid = 1;
        nxt();
        req0_valid = 0; fpu_accepted = 1;
        for (int c = 0; c < 4; c++) begin
            nxt();
            fpu_accepted = 0;
            fpu_calculated = (c == 3);
            fpu_rd = 32'h1234_ABCD;
            #2 chk($sformatf("pr_wait%0d_rvalid", c), t_rvalid, 0);
        end
        nxt();
        fpu_calculated = 0;
        #2;
        chk("pr_rvalid", t_rvalid, 1);
        chk("pr_rerr", t_rerr, 0);
        chk("pr_rdata", t_rdata, 32'h1234_ABCD);
        nxt();

        // Backpressure: RESP held while resp_ready is low; req1 not granted meanwhile.
        do_reset();
        resp_ready = 0;
        req0_valid = 1; req0_tag = 6; req0_rs1 = 32'h0BAD_F00D;
        nxt();
        req0_valid = 0; req1_valid = 1;
        fpu_accepted = 1; fpu_calculated = 1; fpu_rd = 32'h55AA_55AA;
        nxt();
        fpu_accepted = 0; fpu_calculated = 0; fpu_rd = 0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("bp%0d_rvalid", c), m_rvalid, 1);
            chk($sformatf("bp%0d_rdata", c), m_rdata, 32'h55AA_55AA);
            chk($sformatf("bp%0d_rtag", c), m_rtag, 6);
            chk($sformatf("bp%0d_rid", c), m_rid, 0);
            chk($sformatf("bp%0d_r1rdy", c), m_r1rdy, 0);
            nxt();
        end
        resp_ready = 1;
        #2 chk("bp_last_rvalid", m_rvalid, 1);
        nxt();
        #2;
        chk("bp_idle_rvalid", m_rvalid, 0);
        chk("bp_idle_r1rdy", m_r1rdy, 1);
        nxt();

        // Reset mid-WAIT: abandon immediately, then req0 wins first contention.
        do_reset();
        req0_valid = 1;
        nxt();
        req0_valid = 0; fpu_accepted = 1;
        nxt();
        fpu_accepted = 0;
        nxt();
        #2 chk("rw_busy_before", m_busy, 1);
        rstn = 1'b0;
        #1;
        chk("rw_busy", m_busy, 0);
        chk("rw_order", m_order, 0);
        chk("rw_rvalid", m_rvalid, 0);
        nxt();
        rstn = 1'b1;
        req0_valid = 1; req1_valid = 1;
        req0_rs1 = 32'h0000_AAAA; req1_rs1 = 32'h0000_BBBB;
        #2;
        chk("rw_r0rdy", m_r0rdy, 1);
        chk("rw_r1rdy", m_r1rdy, 0);
        nxt();
        #2;
        chk("rw_order", m_order, 1);
        chk("rw_rs1", m_rs1, 32'h0000_AAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameters SHALL be:
- LEN_WORD, 32, operand/result width.
- LEN_FUNC3, 3, func3 width.
- LEN_FUNC7, 7, func7 width.
- LEN_TAG, 5, destination-register tag width.
- TIMEOUT, 255, max WAIT cycles (1..65535).

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req0_valid, req1_valid  in  1  request present.
- reqN_func3 / reqN_func7  in  LEN_FUNC3 / LEN_FUNC7  op select.
- reqN_rs1, reqN_rs2  in  LEN_WORD  operands.
- reqN_tag  in  LEN_TAG  destination tag.
- req0_ready, req1_ready  out  1  request accepted this cycle.
- fpu_order  out  1  issue strobe to FPU.
- fpu_func3, fpu_func7, fpu_rs1, fpu_rs2  out  as request  latched op.
- fpu_accepted, fpu_calculated  in  1  FPU handshake.
- fpu_rd  in  LEN_WORD  FPU result.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_id  out  1  originating requester.
- resp_tag  out  LEN_TAG  latched tag.
- resp_data  out  LEN_WORD  result.
- resp_err  out  1  timeout flag.
- busy  out  1  state != IDLE.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP; one operation is in flight at most.
REQ-004 In IDLE, the arbiter SHALL assert at most one reqN_ready, combinationally, to the granted requester.
- Grant rule: the sole valid requester wins; if both are valid, the requester other than last_grant wins (round robin).
REQ-005 On reqN_valid & reqN_ready, the arbiter SHALL:
- latch func3, func7, rs1, rs2 and tag;
- set resp_id = N and last_grant = N;
- go to ISSUE on the next edge.
REQ-006 In ISSUE, fpu_order SHALL be 1 and held until fpu_accepted is sampled 1.
- accepted without calculated -> WAIT.
- accepted with calculated in the same cycle -> latch fpu_rd, go to RESP.
REQ-007 fpu_order SHALL be 0 in every state other than ISSUE.
REQ-008 fpu_func3, fpu_func7, fpu_rs1 and fpu_rs2 SHALL be driven from the latched registers and stay stable from ISSUE until return to IDLE.
REQ-009 In WAIT, a 16-bit counter (cleared on entry) SHALL increment each cycle.
- fpu_calculated = 1 -> latch fpu_rd into resp_data, resp_err = 0, go to RESP.
- counter reaches TIMEOUT with no calculated -> resp_data = 0, resp_err = 1, go to RESP.
- calculated in the same cycle the counter reaches TIMEOUT -> calculated takes priority.
REQ-010 In RESP, resp_valid SHALL be 1 with resp_id, resp_tag, resp_data and resp_err stable until resp_ready is sampled 1; the next state is then IDLE.
REQ-011 There SHALL be no same-cycle RESP->grant turnaround: both reqN_ready are 0 outside IDLE.
- Minimum latency: handshake at T, fpu_order at T+1, resp_valid at T+2.
REQ-012 fpu_calculated and fpu_accepted SHALL be ignored in IDLE and RESP (e.g. a late result after timeout).
REQ-013 busy SHALL be 1 in ISSUE, WAIT and RESP, and 0 in IDLE.

Reset
REQ-014 rstn low SHALL immediately, regardless of clk:
- force IDLE;
- clear all latched fields and the counter;
- set last_grant = 1, so req0 wins the first contention;
- drive every output to 0.
REQ-015 Reset during ISSUE, WAIT or RESP SHALL abandon the operation with no response; the first edge after rstn rises SHALL sample requests normally.

Verification
REQ-016 The bench SHALL cover these scenarios:
- Single op: req0 op 0x00 (fadd), rs1=0x3F800000, rs2=0x40000000, tag=3; FPU accepted+calculated at T+1 with fpu_rd=0x40400000 -> resp_valid at T+2, resp_id=0, resp_tag=3, resp_data=0x40400000, resp_err=0.
- Contention: both valid continuously after reset, resp_ready=1 -> grants alternate 0,1,0,1 across four ops.
- Multicycle: accepted at T+1, calculated at T+9 -> fpu_order high only at T+1, fpu_rs1/fpu_rs2 stable T+1..T+9, resp_valid at T+10.
- Timeout: TIMEOUT=4, FPU never calculates -> resp_err=1, resp_data=0 after 4 WAIT cycles; calculated pulsed later in IDLE -> no resp_valid.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp fields held, req1_ready stays 0 despite req1_valid=1.
- Reset mid-WAIT: rstn low -> busy, fpu_order, resp_valid all 0 at once; after release, req0 and req1 both valid -> req0 granted.
